// File: rtl/twenty_bit_divider.sv
// Sequential restoring divider: 28-bit dividend / 8-bit divisor -> 20-bit quotient, 8-bit remainder.
// Optional macro TWENTY_BIT_DIVIDER_SATURATE_EN: overflow results saturate to all-ones instead of zero.
module twenty_bit_divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [27:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [19:0] quotient,
  output logic [7:0]  remainder,
  output logic        overflow
);

`ifdef TWENTY_BIT_DIVIDER_SATURATE_EN
  localparam logic [19:0] OVF_QUOTIENT  = 20'hFFFFF;
  localparam logic [7:0]  OVF_REMAINDER = 8'hFF;
`else
  localparam logic [19:0] OVF_QUOTIENT  = 20'h0;
  localparam logic [7:0]  OVF_REMAINDER = 8'h0;
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  div_reg;
  logic [19:0] work;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [8:0]  rem;
  logic [4:0]  cnt;

  logic [8:0]  r_trial;
  logic [8:0]  rem_next;
  logic        q_bit;
  logic        accept;
  logic        ovf_at_accept;

  assign accept        = start && (state != DIVIDE);
  assign ovf_at_accept = dividend[27:20] >= divisor;  // also catches divisor == 0

  always_comb begin
    r_trial  = {rem[7:0], work[19]};
    q_bit    = r_trial >= {1'b0, div_reg};
    rem_next = q_bit ? (r_trial - {1'b0, div_reg}) : r_trial;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = ovf_at_accept ? DONE : DIVIDE;
        else        state_next = IDLE;
      end
      DIVIDE:  if (cnt == 5'd0) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_reg   <= '0;
      work      <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            div_reg <= divisor;
            work    <= dividend[19:0];
            rem     <= {1'b0, dividend[27:20]};
            cnt     <= 5'd19;
            if (ovf_at_accept) begin
              quotient  <= OVF_QUOTIENT;
              remainder <= OVF_REMAINDER;
              overflow  <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          rem  <= rem_next;
          work <= {work[18:0], q_bit};
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            quotient  <= {work[18:0], q_bit};
            remainder <= rem_next[7:0];
            overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == DIVIDE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_twenty_bit_divider.sv
// Self-checking bench for twenty_bit_divider: directed cases plus randomized divisions
// compared against plain-arithmetic division.
module tb_twenty_bit_divider;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [27:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [19:0] quotient;
  logic [7:0]  remainder;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  twenty_bit_divider dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer division; overflow when the quotient needs more than 20 bits.
  task automatic model(input logic [27:0] a, input logic [7:0] b,
                       output logic [19:0] q, output logic [7:0] r, output logic ov);
    longint unsigned qa;
    if (b == 0) begin
      ov = 1'b1;
    end else begin
      qa = longint'(a) / longint'(b);
      ov = (qa > 64'hFFFFF);
    end
    if (ov) begin
`ifdef TWENTY_BIT_DIVIDER_SATURATE_EN
      q = 20'hFFFFF; r = 8'hFF;
`else
      q = 20'h0; r = 8'h0;
`endif
    end else begin
      q = 20'(longint'(a) / longint'(b));
      r = 8'(longint'(a) % longint'(b));
    end
  endtask

  // Waits (bounded) for done after the accepting edge; returns cycles counted from that edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [27:0] a, input logic [7:0] b, input int n);
    logic [19:0] eq; logic [7:0] er; logic eov;
    model(a, b, eq, er, eov);
    check({tag, "_latency"}, n, eov ? 0 : 20);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_overflow"}, overflow, eov);
  endtask

  task automatic run_div(input string tag, input logic [27:0] a, input logic [7:0] b);
    int n;
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(n);
    check_result(tag, a, b, n);
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int n, n2, pulses;
    logic [27:0] a;
    logic [7:0]  b;

    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_outputs", {quotient, remainder, overflow}, 0);
    @(negedge clock); reset_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (done || busy) pulses++;
    end
    check("idle_no_activity", pulses, 0);
    check("idle_outputs", {quotient, remainder, overflow}, 0);

    run_div("basic", 28'd1000000, 8'd7);
    check("basic_exact_q", quotient, 20'h22E09);
    run_div("full_range", 28'hFEFFFFF, 8'hFF);
    check("full_range_exact_q", quotient, 20'hFFFFF);
    run_div("ovf", 28'h0100000, 8'd1);
    run_div("div_zero", 28'd5, 8'd0);
    run_div("after_ovf", 28'd999, 8'd10);

    // start pulsed mid-division with other operands must be ignored
    @(negedge clock); start = 1'b1; dividend = 28'd123456; divisor = 8'd13;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); start = 1'b1; dividend = 28'd77; divisor = 8'd3;
    @(negedge clock); start = 1'b0;
    @(posedge clock); #1;
    n = 7;
    while (!done && n < 40) begin @(posedge clock); #1; n++; end
    check_result("ignore_start", 28'd123456, 8'd13, n);

    // start held through the done cycle: second division accepted back-to-back
    @(negedge clock); start = 1'b1; dividend = 28'd5000000; divisor = 8'd201;
    @(posedge clock); #1;
    dividend = 28'd654321; divisor = 8'd99;
    wait_done(n);
    check_result("b2b_first", 28'd5000000, 8'd201, n);
    @(posedge clock); #1; start = 1'b0;
    n2 = 1;
    while (!done && n2 < 40) begin @(posedge clock); #1; n2++; end
    check("b2b_spacing", n2, 21);
    check_result("b2b_second", 28'd654321, 8'd99, n2 - 1);

    // asynchronous reset mid-division
    @(negedge clock); start = 1'b1; dividend = 28'd8888888; divisor = 8'd37;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_outputs", {quotient, remainder, overflow}, 0);
    pulses = 0;
    repeat (15) begin @(posedge clock); #1; if (done) pulses++; end
    @(negedge clock); reset_n = 1'b1;
    repeat (10) begin @(posedge clock); #1; if (done) pulses++; end
    check("midreset_no_done", pulses, 0);
    run_div("after_reset", 28'd8888888, 8'd37);

    // randomized: mostly in-range quotients, some fully random operands
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(1, 255));
      if (i % 5 == 4) begin
        a = 28'($urandom);
        if (i % 10 == 9) b = 8'($urandom_range(0, 255));
      end else begin
        a = {8'($urandom_range(0, int'(b) - 1)), 20'($urandom)};
      end
      run_div($sformatf("rand%0d", i), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twenty_bit_divider.md
# twenty_bit_divider

Sequential restoring divider that divides a 28-bit dividend by an 8-bit divisor, producing a 20-bit quotient and an 8-bit remainder. It is the inverse of the 20×8 array multiplier in the synth datapath: a value produced as product = a × b can be recovered as a = product / b, with the remainder giving the rounding error. It retires one quotient bit per clock and uses a start/busy/done handshake, so the multi-cycle latency stays off the audio sample-rate critical path.

## Interface
- No parameters. Widths are fixed: dividend 28, divisor 8, quotient 20, remainder 8.

Ports (clock and reset first):
- clock  in  1  rising-edge system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  28  numerator; captured on the accepting edge.
- divisor  in  8  denominator; captured on the accepting edge.
- busy  out  1  high while a division is iterating.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  20  registered result.
- remainder  out  8  registered result.
- overflow  out  1  set when the quotient does not fit in 20 bits, including divide-by-zero.

## Operation
- States: IDLE, DIVIDE, DONE. Reset state is IDLE.
- Accept: start=1 in IDLE or DONE.
  - Latch the divisor and the low 20 bits of the dividend.
  - Load the 9-bit partial remainder with {1'b0, dividend[27:20]}.
  - Load the bit counter with 19.
- Overflow check at accept: if dividend[27:20] >= divisor, go directly to DONE with overflow=1. This condition covers divisor=0.
- Otherwise go to DIVIDE. Each cycle in DIVIDE:
  - Form r = {rem[7:0], next dividend bit}, MSB first.
  - If r >= {1'b0, divisor}, set rem = r − divisor and shift in quotient bit 1.
  - Else set rem = r and shift in quotient bit 0.
  - Decrement the counter.
- When the counter reaches 0 after the 20th bit:
  - Write quotient, remainder = rem[7:0], and overflow=0 to the outputs.
  - Go to DONE.
- The invariant rem < divisor holds throughout, so the remainder always fits in 8 bits.
- DONE lasts exactly one cycle, then returns to IDLE unless start=1 is accepted in that cycle.
- start while busy=1 is ignored and not queued. dividend and divisor may change freely after the accepting edge.
- quotient, remainder, and overflow change only at completion and hold until the next completion.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, overflow=0, state IDLE.
- Reset is asynchronous: asserting reset_n low mid-division aborts it immediately, with no done pulse. Operation resumes on the first edge after release.
- Normal latency: start accepted at edge E0.
  - busy=1 from after E0 through E20.
  - Outputs update and done=1 after E20; busy=0 in that cycle.
  - This gives 20 cycles from accept to done.
- Overflow latency: done=1 after E0, in the cycle after accept; busy stays 0.
- Back-to-back: start=1 during the done cycle is accepted. The sustained rate is one division per 21 cycles.

## Configuration
- Macro: TWENTY_BIT_DIVIDER_SATURATE_EN.
- Defined: on overflow, quotient=20'hFFFFF and remainder=8'hFF.
- Undefined: on overflow, quotient=0 and remainder=0.
- overflow=1 and the overflow timing are identical in both builds.

## Test plan
- Reset, then idle: all outputs 0, busy=0, no done pulse for 50 cycles.
- Basic division: dividend=1000000, divisor=7 -> done 20 cycles after accept, quotient=142857 (20'h22E09), remainder=1, overflow=0.
- Full-range result: dividend=28'hFEFFFFF, divisor=8'hFF -> quotient=20'hFFFFF, remainder=8'hFE, overflow=0.
- Overflow and divide-by-zero: dividend=28'h0100000 with divisor=1, and dividend=5 with divisor=0 -> done one cycle after accept, overflow=1, quotient/remainder per the macro (FFFFF/FF or 0/0).
- Handshake: start pulsed mid-DIVIDE -> ignored and the original result is unchanged. start held through the done cycle -> second division accepted and its done arrives 21 cycles after the first.
- Reset mid-operation: reset_n low at cycle 10 of DIVIDE -> all outputs 0 immediately, no done pulse; a new division after release completes correctly.
